// File: rtl/mem_pair_loader.sv
// mem_pair_loader
//
// Collects a serial stream of DATA_W-bit words into two DEPTH-entry arrays
// (mem_a, then mem_b) and offers them as one frame to a downstream consumer
// under a valid/ready handshake. The frame stays frozen while out_valid is
// high and is released on out_ready. A start-of-frame marker (in_sof)
// realigns the loader at any time; if it arrives mid-frame, resync_err
// pulses for one cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    upstream word valid
//   in_ready    loader can accept a word (decoded from state register)
//   in_data     stream word
//   in_sof      start-of-frame marker, qualified by the accept
//   mem_a       first DEPTH words of the frame
//   mem_b       second DEPTH words of the frame
//   out_valid   mem_a/mem_b hold a complete frame
//   out_ready   consumer takes the frame
//   resync_err  one-cycle pulse after an in_sof accepted mid-frame
//   frame_cnt   number of frames handed off, wraps at 16 bits

module mem_pair_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic [DATA_W-1:0] mem_a [0:DEPTH-1],
    output logic [DATA_W-1:0] mem_b [0:DEPTH-1],
    output logic              out_valid,
    input  logic              out_ready,
    output logic              resync_err,
    output logic [15:0]       frame_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] FILL_A = 2'd0;
    localparam logic [1:0] FILL_B = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             idx_last;

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from in_valid or out_ready to either of them.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);

    assign accept   = in_valid && in_ready;
    assign idx_last = (idx == IDX_W'(DEPTH - 1));

    // Control path: state, write index, resync pulse and handoff counter.
    // An accepted in_sof always restarts the frame at mem_a[0], so the next
    // word lands in mem_a[1]; it is only an error when the loader was not
    // already sitting at the very start of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL_A;
            idx        <= '0;
            resync_err <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            resync_err <= 1'b0;
            if (accept && in_sof) begin
                state      <= FILL_A;
                idx        <= IDX_W'(1);
                resync_err <= !((state == FILL_A) && (idx == '0));
            end else if (accept) begin
                if (idx_last) begin
                    state <= (state == FILL_A) ? FILL_B : HOLD;
                    idx   <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else if ((state == HOLD) && out_ready) begin
                state     <= FILL_A;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Data path: an entry changes only on the edge that accepts its word.
    // Entries are never cleared between frames; a complete frame always
    // overwrites every entry before out_valid rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (accept) begin
            if (in_sof) begin
                mem_a[0] <= in_data;
            end else if (state == FILL_A) begin
                mem_a[idx] <= in_data;
            end else begin
                mem_b[idx] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_pair_loader.sv
// tb_mem_pair_loader
//
// Self-checking bench for mem_pair_loader at default parameters.
// A behavioural frame model (word position within the frame, hold flag,
// handoff count) predicts every output each cycle; a constant vector table
// covers the basic fill/hold/handoff sequence, and hand-written sequences
// cover throughput, resync, random gaps and asynchronous reset.

module tb_mem_pair_loader;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic [DATA_W-1:0] mem_a [0:DEPTH-1];
    logic [DATA_W-1:0] mem_b [0:DEPTH-1];
    logic              out_valid;
    logic              out_ready;
    logic              resync_err;
    logic [15:0]       frame_cnt;

    mem_pair_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .mem_a      (mem_a),
        .mem_b      (mem_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resync_err (resync_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Frame model: number of words collected so far in this frame, whether a
    // full frame is waiting, the expected array contents and handoff count.
    int          m_pos;
    logic        m_hold;
    logic        m_resync;
    logic [15:0] m_frames;
    logic [15:0] m_a [DEPTH];
    logic [15:0] m_b [DEPTH];

    logic        handoff_seen;

    typedef struct {
        logic        v;
        logic        sof;
        logic [15:0] d;
        logic        ordy;
        logic        exp_ov;
        logic        exp_ir;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tbl [37];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic modelReset();
        m_pos    = 0;
        m_hold   = 1'b0;
        m_resync = 1'b0;
        m_frames = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            m_a[i] = 16'd0;
            m_b[i] = 16'd0;
        end
    endtask

    task automatic checkOutput();
        logic arr_ok_a;
        logic arr_ok_b;
        compare("out_valid",  32'(out_valid),  32'(m_hold));
        compare("in_ready",   32'(in_ready),   32'(!m_hold));
        compare("resync_err", 32'(resync_err), 32'(m_resync));
        compare("frame_cnt",  32'(frame_cnt),  32'(m_frames));
        arr_ok_a = 1'b1;
        arr_ok_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_a[i] !== m_a[i]) arr_ok_a = 1'b0;
            if (mem_b[i] !== m_b[i]) arr_ok_b = 1'b0;
        end
        compare("mem_a_all", 32'(arr_ok_a), 32'd1);
        compare("mem_b_all", 32'(arr_ok_b), 32'd1);
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge and
    // compare everything just after the edge.
    task automatic applyStimulus(input logic v, input logic sof, input logic [15:0] d, input logic ordy);
        logic acc;
        logic hand;
        in_valid  = v;
        in_sof    = sof;
        in_data   = d;
        out_ready = ordy;
        acc  = v && !m_hold;
        hand = m_hold && ordy;
        handoff_seen = out_valid && ordy;
        @(posedge clk);
        cycle++;
        m_resync = acc && sof && (m_pos != 0);
        if (acc) begin
            if (sof) m_pos = 0;
            if (m_pos < DEPTH) m_a[m_pos] = d;
            else               m_b[m_pos - DEPTH] = d;
            m_pos++;
            if (m_pos == 2 * DEPTH) begin
                m_pos  = 0;
                m_hold = 1'b1;
            end
        end
        if (hand) begin
            m_hold   = 1'b0;
            m_frames = m_frames + 16'd1;
        end
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    int hcyc[$];
    int guard;

    initial begin
        // Basic fill / hold / handoff vectors with constant expectations.
        for (int i = 0; i < 37; i++) begin
            tbl[i].sof = 1'b0;
            if (i < 16) begin
                tbl[i].v      = 1'b1;
                tbl[i].d      = (i < 8) ? 16'(16'h1111 * (i + 1)) : 16'(i - 7);
                tbl[i].ordy   = 1'b0;
                tbl[i].exp_ov = (i == 15);
                tbl[i].exp_ir = (i != 15);
                tbl[i].exp_fc = 16'd0;
            end else if (i < 36) begin
                tbl[i].v      = 1'b1;
                tbl[i].d      = 16'hDEAD;
                tbl[i].ordy   = 1'b0;
                tbl[i].exp_ov = 1'b1;
                tbl[i].exp_ir = 1'b0;
                tbl[i].exp_fc = 16'd0;
            end else begin
                tbl[i].v      = 1'b1;
                tbl[i].d      = 16'hBEEF;
                tbl[i].ordy   = 1'b1;
                tbl[i].exp_ov = 1'b0;
                tbl[i].exp_ir = 1'b1;
                tbl[i].exp_fc = 16'd1;
            end
        end

        doReset();
        compare("rst_out_valid",  32'(out_valid),  32'd0);
        compare("rst_in_ready",   32'(in_ready),   32'd1);
        compare("rst_resync_err", 32'(resync_err), 32'd0);
        compare("rst_frame_cnt",  32'(frame_cnt),  32'd0);

        for (int i = 0; i < 37; i++) begin
            applyStimulus(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].ordy);
            compare("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
            compare("tbl_in_ready",  32'(in_ready),  32'(tbl[i].exp_ir));
            compare("tbl_frame_cnt", 32'(frame_cnt), 32'(tbl[i].exp_fc));
            if (i == 15 || i == 35) begin
                for (int k = 0; k < DEPTH; k++) begin
                    compare("tbl_mem_a", 32'(mem_a[k]), 32'(16'(16'h1111 * (k + 1))));
                    compare("tbl_mem_b", 32'(mem_b[k]), 32'(k + 1));
                end
            end
        end

        // Throughput: three frames with continuous valid and ready.
        doReset();
        guard = 0;
        while (hcyc.size() < 3 && guard < 200) begin
            applyStimulus(1'b1, 1'b0, 16'($urandom), 1'b1);
            if (handoff_seen) hcyc.push_back(cycle);
            guard++;
        end
        compare("thr_handoffs", 32'(hcyc.size()), 32'd3);
        if (hcyc.size() == 3) begin
            compare("thr_gap1", 32'(hcyc[1] - hcyc[0]), 32'd17);
            compare("thr_gap2", 32'(hcyc[2] - hcyc[1]), 32'd17);
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
        compare("thr_frame_cnt", 32'(frame_cnt), 32'd3);

        // Resync: 5 words, then a mid-frame sof word.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'(i + 1), 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hABCD, 1'b0);
        compare("rsy_pulse", 32'(resync_err), 32'd1);
        compare("rsy_mem_a0", 32'(mem_a[0]), 32'h0000ABCD);
        for (int j = 0; j < 15; j++) begin
            applyStimulus(1'b1, 1'b0, 16'(16'h0100 + j), 1'b0);
            if (j == 0) compare("rsy_pulse_end", 32'(resync_err), 32'd0);
            compare("rsy_out_valid", 32'(out_valid), 32'(j == 14));
        end
        compare("rsy_mem_a0_kept", 32'(mem_a[0]), 32'h0000ABCD);
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);

        // Random gaps, occasional sof, random consumer readiness.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                          16'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Steer into FILL_B, then reset asynchronously between edges.
        guard = 0;
        while (!(m_pos == DEPTH + 2 && !m_hold) && guard < 200) begin
            applyStimulus(1'b1, 1'b0, 16'($urandom), 1'b1);
            guard++;
        end
        compare("ar_reach_fill_b", 32'(m_pos), 32'(DEPTH + 2));
        #2;
        rst = 1'b1;
        #1;
        compare("ar_out_valid", 32'(out_valid),  32'd0);
        compare("ar_in_ready",  32'(in_ready),   32'd1);
        compare("ar_resync",    32'(resync_err), 32'd0);
        compare("ar_frame_cnt", 32'(frame_cnt),  32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            compare("ar_mem_a", 32'(mem_a[k]), 32'd0);
            compare("ar_mem_b", 32'(mem_b[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b1, 1'b0, 16'(16'h5000 + i), 1'b0);
        compare("ar_clean_frame", 32'(out_valid), 32'd1);
        compare("ar_clean_b7", 32'(mem_b[DEPTH-1]), 32'(16'h5000 + 2 * DEPTH - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_pair_loader.md
# mem_pair_loader

Stream-to-array loader that sits directly upstream of the dual-memory arithmetic stage. It collects a serial stream of DATA_W-bit words into two DEPTH-entry unpacked arrays, `mem_a` and `mem_b`, and presents them as one frame under a valid/ready handshake. Its outputs connect one-to-one to the consumer's `mem_a`/`mem_b` unpacked input ports. The frame is held stable until the consumer accepts it.

## Interface
- `DATA_W`, default 16: word width. Matches the consumer's `[15:0]` memory entries.
- `DEPTH`, default 8: entries per array. Must be a power of two, ≥2.
- `clk`  input  1: sole clock. All logic is rising-edge.
- `rst`  input  1: reset, asynchronous and active-high. Clears all state immediately.
- `in_valid`  input  1: upstream word valid.
- `in_ready`  output  1: loader can accept a word.
- `in_data`  input  DATA_W: stream word.
- `in_sof`  input  1: start-of-frame marker, qualified by the accept.
- `mem_a`  output  [DATA_W-1:0] x [0:DEPTH-1]: first half of the frame.
- `mem_b`  output  [DATA_W-1:0] x [0:DEPTH-1]: second half of the frame.
- `out_valid`  output  1: `mem_a`/`mem_b` hold a complete frame.
- `out_ready`  input  1: consumer takes the frame.
- `resync_err`  output  1: one-cycle pulse when `in_sof` arrives mid-frame.
- `frame_cnt`  output  16: count of frames handed off. Wraps from 16'hFFFF to 0.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready` is 1 in FILL_A and FILL_B, and 0 in HOLD.
- States:
  - FILL_A: an accepted word is written to `mem_a[idx]`. When `idx == DEPTH-1`, go to FILL_B with `idx` = 0; otherwise `idx`++.
  - FILL_B: an accepted word is written to `mem_b[idx]`. When `idx == DEPTH-1`, go to HOLD with `idx` = 0.
  - HOLD: `out_valid` = 1 and both arrays are frozen. On `out_ready`: go to FILL_A, `out_valid` = 0 next cycle, `frame_cnt`++.
- `in_sof` on an accepted word:
  - The word is always written to `mem_a[0]`; next state is FILL_A with `idx` = 1.
  - If this happens anywhere other than FILL_A with `idx` == 0, assert `resync_err` for exactly one cycle (the cycle after the accept).
  - The partial frame is discarded. Stale entries remain until overwritten.
- `in_sof` = 0 on the first word of a frame is legal. The marker is optional for alignment.
- Entries are never cleared between frames; each frame overwrites all 2*DEPTH entries before `out_valid` rises.
- `in_sof` and `in_data` are ignored when the word is not accepted.
- Reset values: state = FILL_A, `idx` = 0, `in_ready` = 1 once `rst` is released, `out_valid` = 0, `resync_err` = 0, `frame_cnt` = 0, all `mem_a`/`mem_b` entries = 0.
- Reset mid-frame or mid-HOLD abandons the frame; no handoff and no count increment occur.

## Timing
- `in_ready` and `out_valid` are registered outputs, decoded from the state register. There is no combinational path from `in_valid` or `out_ready`.
- Last `mem_b` word accepted in cycle N → `out_valid` = 1 and `in_ready` = 0 in cycle N+1.
- Handoff in cycle M (`out_valid && out_ready`) → `in_ready` = 1 and `out_valid` = 0 in cycle M+1; `frame_cnt` updates in M+1.
- There is no input bypass during the handoff cycle.
- Minimum frame period is 2*DEPTH+1 cycles (17 at defaults), with continuous `in_valid` and `out_ready` held at 1.
- Array entries change only on the clock edge that accepts the corresponding word.
- A consumer sampling in any cycle with `out_valid` = 1 sees stable data.
- `out_ready` while `out_valid` = 0 has no effect.

## Test plan
- Reset, then 16 back-to-back words 16'h1111…16'h8888 followed by 16'h0001…16'h0008, with `out_ready` = 0:
  - `mem_a` = {1111…8888}, `mem_b` = {0001…0008}.
  - `out_valid` rises the cycle after the 16th accept; `in_ready` = 0; arrays are stable for 20 cycles.
- From the previous state, pulse `out_ready` for 1 cycle → `out_valid` drops next cycle, `frame_cnt` = 1, `in_ready` = 1.
- Throughput: continuous `in_valid` with `out_ready` = 1 for 3 frames → handoffs occur exactly 17 cycles apart; `frame_cnt` = 3.
- Resync: 5 words, then a word 16'hABCD with `in_sof` = 1:
  - `resync_err` pulses for exactly 1 cycle; `mem_a[0]` = 16'hABCD.
  - The frame completes after 15 more words, not 10.
- Gaps: random `in_valid` deassertion (about 50%) → arrays contain exactly the accepted words in order; no word is lost or duplicated.
- Assert `rst` asynchronously during FILL_B (between clock edges) → all outputs immediately return to reset values, including `mem_a`/`mem_b` = 0 and `frame_cnt` = 0. The next 16 words form a clean frame.
